// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg: shared NOP constant, grant FSM encoding and clog2 helper
package instr_mem_responder_pkg;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {G_IDLE, G_WAIT, G_GRANT} gnt_state_e;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/instr_rsp_pipe.sv
// instr_rsp_pipe: DEPTH-stage valid/data/err delay line (clk_i, rst_ni, valid_i/data_i/err_i in, valid_o/data_o/err_o out); payload only moves with a valid token so the output holds the last response
module instr_rsp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);
  logic [DEPTH-1:0] v_c;
  logic [DEPTH-1:0] v_q;
  logic [32:0] p_c [DEPTH];
  logic [32:0] p_q [DEPTH];
  always_comb begin
    v_c[0] = valid_i;
    p_c[0] = {err_i, data_i};
    for (int i = 1; i < DEPTH; i++) begin
      v_c[i] = v_q[i-1];
      p_c[i] = p_q[i-1];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) p_q[i] <= '0;
    end else begin
      v_q <= v_c;
      for (int i = 0; i < DEPTH; i++) if (v_c[i]) p_q[i] <= p_c[i];
    end
  assign valid_o = v_q[DEPTH-1];
  assign {err_o, data_o} = p_q[DEPTH-1];
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction memory responder (CLK, RES_N; instr_req/addr in, instr_gnt/r_valid/rdata/err out; prog_we/addr/wdata backdoor)
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS     = 1024,
  parameter int GNT_DELAY       = 0,
  parameter int RSP_LATENCY     = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_r_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);
  localparam int AW = clog2(DEPTH_WORDS);
  localparam int CW = clog2(GNT_DELAY + 1) + 1;
  localparam int OW = clog2(MAX_OUTSTANDING + 1) + 1;
  logic [31:0] mem_q [DEPTH_WORDS];
  gnt_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, held;
  logic [OW-1:0] out_q, out_d;
  logic rd_err, wr_ok, ready;
  logic [31:0] rd_data;
  always_comb begin
    held = (state_q == G_WAIT) ? cnt_q : '0;
    ready = held == CW'(GNT_DELAY);
    instr_gnt = RES_N && instr_req && ready && out_q < OW'(MAX_OUTSTANDING);
    state_d = instr_gnt ? G_GRANT : instr_req ? G_WAIT : G_IDLE;
    cnt_d = (!instr_req || instr_gnt) ? '0 : ready ? held : held + 1'b1;
    out_d = out_q + OW'(instr_gnt) - OW'(instr_r_valid);
    rd_err = instr_addr[1:0] != 2'b00 || instr_addr[31:AW+2] != '0;
    rd_data = rd_err ? INSTR_NOP : mem_q[instr_addr[AW+1:2]];
    wr_ok = prog_we && prog_addr[1:0] == 2'b00 && prog_addr[31:AW+2] == '0;
  end
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      state_q <= G_IDLE;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  // storage is deliberately outside reset; the read above sees the pre-write word
  always_ff @(posedge CLK)
    if (wr_ok) mem_q[prog_addr[AW+1:2]] <= prog_wdata;
  instr_rsp_pipe #(.DEPTH(RSP_LATENCY)) u_pipe (
    .clk_i  (CLK),
    .rst_ni (RES_N),
    .valid_i(instr_gnt),
    .data_i (rd_data),
    .err_i  (rd_err),
    .valid_o(instr_r_valid),
    .data_o (instr_rdata),
    .err_o  (instr_err)
  );
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed vector bench over three parameterisations of instr_mem_responder
module tb_instr_mem_responder;
  localparam int GD [3] = '{0, 2, 0};
  localparam int RL [3] = '{1, 1, 3};
  localparam int MO [3] = '{1, 1, 2};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [3];
  logic [31:0] addr [3];
  logic gnt [3];
  logic rv [3];
  logic [31:0] rdata [3];
  logic err [3];
  logic pwe = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwd = '0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_responder #(
      .DEPTH_WORDS(16), .GNT_DELAY(GD[g]), .RSP_LATENCY(RL[g]), .MAX_OUTSTANDING(MO[g])
    ) u_dut (
      .CLK(clk), .RES_N(rst_n), .instr_req(req[g]), .instr_addr(addr[g]),
      .instr_gnt(gnt[g]), .instr_r_valid(rv[g]), .instr_rdata(rdata[g]), .instr_err(err[g]),
      .prog_we(pwe), .prog_addr(paddr), .prog_wdata(pwd)
    );
  end
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t tv [11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic outs(input int g, input logic eg, input logic erv, input logic [31:0] erd, input logic eer, input string nm);
    chk($sformatf("%s.gnt", nm), {31'b0, gnt[g]}, {31'b0, eg});
    chk($sformatf("%s.rvalid", nm), {31'b0, rv[g]}, {31'b0, erv});
    chk($sformatf("%s.rdata", nm), rdata[g], erd);
    chk($sformatf("%s.err", nm), {31'b0, err[g]}, {31'b0, eer});
  endtask
  task automatic step(input int g, input logic rq, input logic [31:0] a, input logic eg, input logic erv, input logic [31:0] erd, input logic eer, input string nm);
    @(negedge clk);
    req[g] = rq;
    addr[g] = a;
    #1;
    outs(g, eg, erv, erd, eer, nm);
  endtask
  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pwe = 1'b1;
    paddr = a;
    pwd = d;
    @(posedge clk);
    #1 pwe = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0]  = '{1'b1, 32'd0,  1'b1, 1'b0, 32'h0,         1'b0};
    tv[1]  = '{1'b1, 32'd4,  1'b0, 1'b1, 32'h0050_0093, 1'b0};
    tv[2]  = '{1'b1, 32'd4,  1'b1, 1'b0, 32'h0050_0093, 1'b0};
    tv[3]  = '{1'b0, 32'd0,  1'b0, 1'b1, 32'h0011_0113, 1'b0};
    tv[4]  = '{1'b1, 32'd2,  1'b1, 1'b0, 32'h0011_0113, 1'b0};
    tv[5]  = '{1'b0, 32'd0,  1'b0, 1'b1, 32'h0000_0013, 1'b1};
    tv[6]  = '{1'b1, 32'd64, 1'b1, 1'b0, 32'h0000_0013, 1'b1};
    tv[7]  = '{1'b0, 32'd0,  1'b0, 1'b1, 32'h0000_0013, 1'b1};
    tv[8]  = '{1'b1, 32'd0,  1'b1, 1'b0, 32'h0000_0013, 1'b1};
    tv[9]  = '{1'b0, 32'd0,  1'b0, 1'b1, 32'h0050_0093, 1'b0};
    tv[10] = '{1'b0, 32'd0,  1'b0, 1'b0, 32'h0050_0093, 1'b0};
    for (int g = 0; g < 3; g++) begin
      req[g] = 1'b1;
      addr[g] = '0;
    end
    prog(32'd0, 32'h0050_0093);
    prog(32'd4, 32'h0011_0113);
    prog(32'd8, 32'h0022_0233);
    prog(32'd64, 32'hFFFF_FFFF);
    prog(32'd6, 32'hEEEE_EEEE);
    @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) outs(g, 1'b0, 1'b0, 32'h0, 1'b0, $sformatf("reset%0d", g));
    for (int g = 0; g < 3; g++) req[g] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++)
      step(0, tv[i].req, tv[i].addr, tv[i].gnt, tv[i].rv, tv[i].rd, tv[i].err, $sformatf("vec%0d", i));
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 1'b0, "dly_c0");
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 1'b0, "dly_c1");
    step(1, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0, 1'b0, "dly_c2");
    step(1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0011_0113, 1'b0, "dly_rsp");
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "dly_short");
    step(1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "dly_drop");
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "dly_r0");
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "dly_r1");
    step(1, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0011_0113, 1'b0, "dly_r2");
    step(1, 1'b1, 32'd4, 1'b0, 1'b1, 32'h0011_0113, 1'b0, "dly_h0");
    step(1, 1'b1, 32'd4, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "dly_h1");
    step(1, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0011_0113, 1'b0, "dly_h2");
    step(1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0011_0113, 1'b0, "dly_hrsp");
    step(2, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0, "out_c0");
    step(2, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0, 1'b0, "out_c1");
    step(2, 1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 1'b0, "out_full");
    step(2, 1'b1, 32'd8, 1'b0, 1'b1, 32'h0050_0093, 1'b0, "out_rsp0");
    step(2, 1'b1, 32'd8, 1'b1, 1'b1, 32'h0011_0113, 1'b0, "out_rsp1");
    step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "out_c5");
    step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0011_0113, 1'b0, "out_c6");
    step(2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0022_0233, 1'b0, "out_rsp2");
    step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0022_0233, 1'b0, "out_c8");
    @(negedge clk);
    req[0] = 1'b1;
    addr[0] = 32'd8;
    pwe = 1'b1;
    paddr = 32'd8;
    pwd = 32'hDEAD_BEEF;
    #1;
    outs(0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, "col_gnt");
    @(posedge clk);
    #1 pwe = 1'b0;
    step(0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0022_0233, 1'b0, "col_old");
    step(0, 1'b1, 32'd8, 1'b1, 1'b0, 32'h0022_0233, 1'b0, "col_rd");
    step(0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, "col_new");
    step(2, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0022_0233, 1'b0, "rst_a");
    step(2, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0022_0233, 1'b0, "rst_b");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs(2, 1'b0, 1'b0, 32'h0, 1'b0, "rst_mid");
    @(negedge clk);
    req[2] = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, $sformatf("rst_quiet%0d", i));
    step(2, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0, "rst_reread");
    step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, "rst_wait1");
    step(2, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, "rst_wait2");
    step(2, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, "rst_rsp");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
